// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants, state encoding and round-constant lookup
//               for the AES-128 decryption key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NR          = 10;
  localparam int ROUND_KEY_W = 128;

  // Round constants, first byte of Rcon[i] for i = 1..NR
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Out-of-table indices yield zero so callers never read undefined entries
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'(NR)) begin
      return RCON[r];
    end
    return 8'h00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_key_schedule_if.sv
`default_nettype none
// ============================================================================
// Module      : inv_key_schedule_if
// Description : Control/read bus between the inverse-cipher controller
//               (master) and the round-key generator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface inv_key_schedule_if;
  import aes_pkg::*;

  logic                     start;
  logic [0:ROUND_KEY_W-1]   key;
  logic [3:0]               rd_idx;
  logic [0:ROUND_KEY_W-1]   rd_key;
  logic                     busy;
  logic                     ready;

  modport master (
    output start, key, rd_idx,
    input  rd_key, busy, ready
  );

  modport slave (
    input  start, key, rd_idx,
    output rd_key, busy, ready
  );

endinterface
`default_nettype wire

// File: rtl/sbox_byte.sv
`default_nettype none
// ============================================================================
// Module      : sbox_byte
// Description : Forward AES S-box, one byte, purely combinational lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_byte (
  input  logic [7:0] data_byte,
  output logic [7:0] sub_byte
);

  // Table stored MSB-first so entry n occupies bits [8n : 8n+7]
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base     = {data_byte, 3'b000};
  assign sub_byte = SBOX_TABLE[base +: 8];

endmodule
`default_nettype wire

// File: rtl/inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : inv_key_schedule
// Description : AES-128 key expansion, one round key per clock into an
//               11-entry register file, read by index for decryption.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  inv_key_schedule_if.slave bus
);

  state_t                 state;
  state_t                 state_next;
  logic [3:0]             rc;
  logic [0:ROUND_KEY_W-1] rk [0:NR];
  logic                   start_ok;

  logic [0:ROUND_KEY_W-1] prev_key;
  logic [0:ROUND_KEY_W-1] next_key;
  logic [0:ROUND_KEY_W-1] rd_data;
  logic [0:31]            w0, w1, w2, w3;
  logic [0:31]            rot_word;
  logic [0:31]            sub_word;
  logic [0:31]            t_word;
  logic [0:31]            n0, n1, n2, n3;

  // A start during expansion is dropped so the running schedule is never corrupted
  assign start_ok = bus.start && (state != EXPAND);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: leave EXPAND on the edge that writes the last key
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start)         state_next = EXPAND;
      EXPAND:  if (rc == 4'(NR))      state_next = READY;
      READY:   if (bus.start)         state_next = EXPAND;
      default:                        state_next = IDLE;
    endcase
  end

  // Round counter: points at the entry written on the next EXPAND edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc <= 4'd0;
    end else if (start_ok) begin
      rc <= 4'd1;
    end else if (state == EXPAND) begin
      rc <= rc + 4'd1;
    end
  end

  // Previous round key; rc is always 1..NR while it matters
  always_comb begin
    prev_key = '0;
    if (rc != 4'd0 && rc <= 4'(NR)) begin
      prev_key = rk[rc - 4'd1];
    end
  end

  assign w0       = prev_key[0:31];
  assign w1       = prev_key[32:63];
  assign w2       = prev_key[64:95];
  assign w3       = prev_key[96:127];
  assign rot_word = {w3[8:31], w3[0:7]};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_subword
      sbox_byte u_sbox (
        .data_byte (rot_word[i*8 +: 8]),
        .sub_byte  (sub_word[i*8 +: 8])
      );
    end
  endgenerate

  assign t_word   = sub_word ^ {rcon_of(rc), 24'h000000};
  assign n0       = w0 ^ t_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Register file: at most one entry changes per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) begin
        rk[i] <= '0;
      end
    end else if (start_ok) begin
      rk[0] <= bus.key;
    end else if (state == EXPAND) begin
      rk[rc] <= next_key;
    end
  end

  // Zero-latency read; indices past the last round key read as zero
  always_comb begin
    rd_data = '0;
    if (bus.rd_idx <= 4'(NR)) begin
      rd_data = rk[bus.rd_idx];
    end
  end

  assign bus.rd_key = rd_data;
  assign bus.busy   = (state == EXPAND);
  assign bus.ready  = (state == READY);

endmodule
`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_key_schedule
// Description : Directed self-checking bench for the AES-128 key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_key_schedule;

  localparam logic [0:127] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] A_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [0:127] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  inv_key_schedule_if bus ();

  inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [0:127] val);
    bus.rd_idx = idx;
    #1;
    val = bus.rd_key;
  endtask

  // Drives start for exactly one edge (E0)
  task automatic pulse_start(input logic [0:127] k);
    bus.key   = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts edges after E0 until ready, bounded
  task automatic wait_ready(input int start_cnt, output int cnt, output bit overlap);
    cnt     = start_cnt;
    overlap = 1'b0;
    while (!bus.ready && cnt < 20) begin
      tick();
      cnt++;
      if (bus.busy && bus.ready) overlap = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [0:127] v;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.key    = '0;
    bus.rd_idx = 4'd0;
    tick();
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b ready=%b expected 0/0", bus.busy, bus.ready);
    end
    read_key(4'd0, v);
    n_checks++;
    if (v !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rk0: got %h expected 0", v);
    end
    read_key(4'd10, v);
    n_checks++;
    if (v !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rk10: got %h expected 0", v);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_key;
    logic [0:127] v;
    int cnt;
    bit ov;
    pulse_start(KEY_A);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_after_e0: busy=%b ready=%b expected 1/0", bus.busy, bus.ready);
    end
    read_key(4'd0, v);
    n_checks++;
    if (v !== KEY_A) begin
      n_fail++;
      $display("FAIL fips_rk0_after_e0: got %h expected %h", v, KEY_A);
    end
    wait_ready(0, cnt, ov);
    n_checks++;
    if (cnt !== 10 || ov) begin
      n_fail++;
      $display("FAIL fips_latency: got %0d overlap=%0d expected 10/0", cnt, ov);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_busy_done: got %b expected 0", bus.busy);
    end
    read_key(4'd1, v);
    n_checks++;
    if (v !== A_RK1) begin
      n_fail++;
      $display("FAIL fips_rk1: got %h expected %h", v, A_RK1);
    end
    read_key(4'd2, v);
    n_checks++;
    if (v !== A_RK2) begin
      n_fail++;
      $display("FAIL fips_rk2: got %h expected %h", v, A_RK2);
    end
    read_key(4'd10, v);
    n_checks++;
    if (v !== A_RK10) begin
      n_fail++;
      $display("FAIL fips_rk10: got %h expected %h", v, A_RK10);
    end
  endtask

  task automatic test_key_b;
    logic [0:127] v;
    int cnt;
    bit ov;
    pulse_start(KEY_B);
    wait_ready(0, cnt, ov);
    n_checks++;
    if (cnt !== 10) begin
      n_fail++;
      $display("FAIL keyb_latency: got %0d expected 10", cnt);
    end
    read_key(4'd10, v);
    n_checks++;
    if (v !== B_RK10) begin
      n_fail++;
      $display("FAIL keyb_rk10: got %h expected %h", v, B_RK10);
    end
    read_key(4'd0, v);
    n_checks++;
    if (v !== KEY_B) begin
      n_fail++;
      $display("FAIL keyb_rk0: got %h expected %h", v, KEY_B);
    end
  endtask

  task automatic test_out_of_range;
    logic [0:127] v;
    read_key(4'd11, v);
    n_checks++;
    if (v !== 128'h0) begin
      n_fail++;
      $display("FAIL idx11: got %h expected 0", v);
    end
    read_key(4'd15, v);
    n_checks++;
    if (v !== 128'h0) begin
      n_fail++;
      $display("FAIL idx15: got %h expected 0", v);
    end
  endtask

  task automatic test_ignored_start;
    logic [0:127] v;
    int cnt;
    bit ov;
    pulse_start(KEY_A);
    tick();
    tick();
    tick();
    bus.key   = KEY_B;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_ready(4, cnt, ov);
    n_checks++;
    if (cnt !== 10 || ov) begin
      n_fail++;
      $display("FAIL ignored_latency: got %0d overlap=%0d expected 10/0", cnt, ov);
    end
    read_key(4'd0, v);
    n_checks++;
    if (v !== KEY_A) begin
      n_fail++;
      $display("FAIL ignored_rk0: got %h expected %h", v, KEY_A);
    end
    read_key(4'd10, v);
    n_checks++;
    if (v !== A_RK10) begin
      n_fail++;
      $display("FAIL ignored_rk10: got %h expected %h", v, A_RK10);
    end
  endtask

  task automatic test_reset_mid;
    logic [0:127] v;
    int cnt;
    bit ov;
    pulse_start(KEY_B);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_flags: busy=%b ready=%b expected 0/0", bus.busy, bus.ready);
    end
    read_key(4'd0, v);
    n_checks++;
    if (v !== 128'h0) begin
      n_fail++;
      $display("FAIL midrst_rk0: got %h expected 0", v);
    end
    tick();
    rst = 1'b0;
    tick();
    pulse_start(KEY_A);
    wait_ready(0, cnt, ov);
    n_checks++;
    if (cnt !== 10) begin
      n_fail++;
      $display("FAIL midrst_relatency: got %0d expected 10", cnt);
    end
    read_key(4'd10, v);
    n_checks++;
    if (v !== A_RK10) begin
      n_fail++;
      $display("FAIL midrst_rk10: got %h expected %h", v, A_RK10);
    end
  endtask

  task automatic test_restart;
    logic [0:127] v;
    int cnt;
    bit ov;
    pulse_start(KEY_B);
    n_checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_flags: busy=%b ready=%b expected 1/0", bus.busy, bus.ready);
    end
    read_key(4'd10, v);
    n_checks++;
    if (v !== A_RK10) begin
      n_fail++;
      $display("FAIL restart_stale_rk10: got %h expected %h", v, A_RK10);
    end
    wait_ready(0, cnt, ov);
    n_checks++;
    if (cnt !== 10) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d expected 10", cnt);
    end
    read_key(4'd10, v);
    n_checks++;
    if (v !== B_RK10) begin
      n_fail++;
      $display("FAIL restart_rk10: got %h expected %h", v, B_RK10);
    end
  endtask

  task automatic test_start_at_end;
    logic [0:127] v;
    pulse_start(KEY_A);
    for (int i = 0; i < 9; i++) tick();
    bus.key   = KEY_B;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL end_start_flags: busy=%b ready=%b expected 0/1", bus.busy, bus.ready);
    end
    tick();
    n_checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL end_start_hold: busy=%b ready=%b expected 0/1", bus.busy, bus.ready);
    end
    read_key(4'd0, v);
    n_checks++;
    if (v !== KEY_A) begin
      n_fail++;
      $display("FAIL end_start_rk0: got %h expected %h", v, KEY_A);
    end
  endtask

  initial begin
    test_reset();
    test_fips_key();
    test_key_b();
    test_out_of_range();
    test_ignored_start();
    test_reset_mid();
    test_restart();
    test_start_at_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
